rr_mux_arbiter_16: RTL and testbench
====================================

Name: rr_mux_arbiter_16

Overview:
- Round-robin arbiter and sequencer that shares one 32-bit output channel among 16 requesters.
- Each cycle it picks one requester, drives its 4-bit select, captures that requester's 32-bit word into an output register, and presents it to a single consumer over a valid/ready handshake.
- It sits between the register-file/peripheral sources and any shared sink, such as the debug/display bus or the write-back port.

Parameters:
- DW, 32, data width of each source and of o_data.
- NREQ, 16, number of requesters; fixed at 16 because the select is 4 bits.
- SELW, 4, select width, log2(NREQ).

Ports:
- clk  in  1  system clock; rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  16  request vector; bit i high means source i has a word pending.
- iData  in  512  flattened sources; source i occupies bits [32*i+31 : 32*i].
- o_ready  in  1  consumer can accept o_data this cycle.
- o_valid  out  1  o_data/o_src hold a granted word.
- o_data  out  32  captured word of the granted source.
- o_src  out  4  index of the granted source; this is the registered select.
- ack  out  16  one-hot and combinational; equals onehot(o_src) when o_valid && o_ready.
- busy  out  1  high while the FSM is in BUSY.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, ptr=0, o_valid=0, o_data=0, o_src=0, busy=0, ack=0.
  - Reset mid-transfer drops the pending word silently; no ack is issued.
- Pick function:
  - Search req cyclically starting at index ptr: ptr, ptr+1, ... 15, 0, ... ptr-1.
  - The first set bit wins.
  - Index arithmetic is mod 16 (4-bit wrap).
- IDLE:
  - If req != 0, then on the next edge: o_src<=win, o_data<=iData[win], o_valid<=1, state<=BUSY.
  - If req == 0, hold.
  - Latency from req rising to o_valid is 1 cycle.
- BUSY:
  - o_valid=1. o_data and o_src are stable until the handshake; changes on req or iData have no effect on them.
  - Handshake occurs when o_valid && o_ready.
    - ack[o_src]=1 in that cycle.
    - ptr<=o_src+1 (wraps 15 -> 0).
  - Back-to-back on handshake:
    - Re-pick using req & ~onehot(o_src), starting from o_src+1.
    - If a winner exists, load it on the same edge and stay in BUSY. Throughput is 1 word/cycle.
    - Otherwise o_valid<=0 and state<=IDLE.
  - Without a handshake, hold everything and do not re-arbitrate (no grant switching while valid).
- Requester contract:
  - Keep req high and iData stable until ack is seen; drop req in the cycle after ack.
  - A source that keeps req high after its ack is re-eligible only on a later pick, which is what gives fairness.
- Fairness: with all 16 requesting and o_ready=1, grants rotate 0,1,...,15,0; no source waits more than 15 transfers.
- Consumer rule: o_ready high while o_valid=0 has no effect.
- Width: o_data is zero-extended only at reset; no other transformation.

Decomposition:
- Shared package holds:
  - NREQ=16, SELW=4, DW=32.
  - State encoding: IDLE=1'b0, BUSY=1'b1.
  - The onehot16 function.
- Sub-module rr_pick16, purely combinational:
  - Inputs: req[15:0], ptr[3:0].
  - Outputs: win[3:0], any.
  - Implementation: rotate right by ptr, fixed-priority encode, add ptr back mod 16.
- The top level instantiates rr_pick16 twice: once on raw req for the IDLE pick, once on masked req for the back-to-back re-pick.

Test Plan:
- Reset then single request: rst_n low with req=16'h0010 asserted; release. Expect o_valid=0 during reset. One cycle after release: o_valid=1, o_src=4, o_data=iData4 (0xDEAD0004). With o_ready=1, ack=16'h0010 that cycle and ptr becomes 5.
- Full rotation: req=16'hFFFF held, o_ready=1, iData_i=0x1000+i. Expect one grant per cycle with o_src sequence 0,1,2,...,15,0, o_data matching each, and busy=1 throughout.
- Backpressure: req=16'h0101, o_ready=0 for 5 cycles. Expect o_src=0 and o_data stable while iData0 changes. When o_ready=1: ack=16'h0001, next o_src=8, then o_src=0 only if req0 is still high.
- Wrap priority: with ptr=15 (after serving source 14), req=16'h8001. Expect o_src=15 first, then 0.
- Async reset mid-BUSY: assert rst_n=0 between edges while o_valid=1. Expect o_valid=0, ack=0, busy=0 immediately without waiting for a clock edge. After release, arbitration starts with ptr=0.
- Idle/no request: req=0 with o_ready toggling. Expect o_valid=0, ack=0, state remains IDLE.

Source files
------------

// File: rtl/rr_mux_arbiter_16_pkg.sv
// rr_mux_arbiter_16_pkg: shared sizes, FSM encoding and one-hot helper for the 16-way arbiter
package rr_mux_arbiter_16_pkg;
    localparam int NREQ = 16;
    localparam int SELW = 4;
    localparam int DW   = 32;

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    function automatic logic [NREQ-1:0] onehot16(input logic [SELW-1:0] idx);
        onehot16 = NREQ'(1) << idx;
    endfunction
endpackage

// File: rtl/rr_mux_arbiter_16_pick.sv
// rr_pick16: cyclic first-set-bit search over 16 requests starting at ptr_i
module rr_pick16
    import rr_mux_arbiter_16_pkg::*;
(
    input  logic [NREQ-1:0] req_i,
    input  logic [SELW-1:0] ptr_i,
    output logic [SELW-1:0] win_o,
    output logic            any_o
);
    logic [NREQ-1:0] rot;
    logic [SELW-1:0] idx;

    assign rot = NREQ'({req_i, req_i} >> ptr_i);

    // lowest set bit of the rotated vector is the nearest requester at or after ptr_i
    always_comb begin
        idx = '0;
        for (int i = NREQ - 1; i >= 0; i--) idx = rot[i] ? SELW'(i) : idx;
    end

    assign win_o = idx + ptr_i;
    assign any_o = |req_i;
endmodule

// File: rtl/rr_mux_arbiter_16.sv
// rr_mux_arbiter_16: round-robin sharing of one 32-bit valid/ready channel among 16 sources
module rr_mux_arbiter_16
    import rr_mux_arbiter_16_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*DW-1:0]   iData,
    input  logic                 o_ready,
    output logic                 o_valid,
    output logic [DW-1:0]        o_data,
    output logic [SELW-1:0]      o_src,
    output logic [NREQ-1:0]      ack,
    output logic                 busy
);
    state_t          state_q, state_d;
    logic [SELW-1:0] ptr_q, ptr_d, src_q, src_d;
    logic [DW-1:0]   data_q, data_d;
    logic [SELW-1:0] win_idle, win_next, src_nx;
    logic            any_idle, any_next, hs;

    assign src_nx = src_q + 1'b1;
    assign hs     = (state_q == BUSY) && o_ready;

    rr_pick16 u_pick_idle (
        .req_i (req),
        .ptr_i (ptr_q),
        .win_o (win_idle),
        .any_o (any_idle)
    );

    // the just-served source is masked so a back-to-back re-pick cannot grant it twice in a row
    rr_pick16 u_pick_next (
        .req_i (req & ~onehot16(src_q)),
        .ptr_i (src_nx),
        .win_o (win_next),
        .any_o (any_next)
    );

    // grant from IDLE, or on a handshake advance the pointer and chain the next winner
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        src_d   = src_q;
        data_d  = data_q;
        if (state_q == IDLE && any_idle) begin
            state_d = BUSY;
            src_d   = win_idle;
            data_d  = iData[DW*win_idle +: DW];
        end else if (hs) begin
            ptr_d   = src_nx;
            src_d   = any_next ? win_next : src_q;
            data_d  = any_next ? iData[DW*win_next +: DW] : data_q;
            state_d = any_next ? BUSY : IDLE;
        end
    end

    // state and captured word; reset drops any pending word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            src_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            src_q   <= src_d;
            data_q  <= data_d;
        end
    end

    assign o_valid = state_q == BUSY;
    assign busy    = state_q == BUSY;
    assign o_src   = src_q;
    assign o_data  = data_q;
    assign ack     = hs ? onehot16(src_q) : '0;
endmodule

// File: tb/tb_rr_mux_arbiter_16.sv
// tb_rr_mux_arbiter_16: random and directed checks of the arbiter against a transaction-level model
module tb_rr_mux_arbiter_16;
    logic         clk = 1'b0;
    logic         rst_n;
    logic [15:0]  req;
    logic [511:0] idata;
    logic         o_ready;
    logic         o_valid, busy;
    logic [31:0]  o_data;
    logic [3:0]   o_src;
    logic [15:0]  ack;
    logic [31:0]  src_data [16];

    int total = 0;
    int bad   = 0;

    bit          m_valid;
    int          m_src, m_ptr;
    logic [31:0] m_data;

    rr_mux_arbiter_16 dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .iData   (idata),
        .o_ready (o_ready),
        .o_valid (o_valid),
        .o_data  (o_data),
        .o_src   (o_src),
        .ack     (ack),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    always_comb begin
        idata = '0;
        for (int i = 0; i < 16; i++) idata[32*i +: 32] = src_data[i];
    end

    function automatic int pick(input logic [15:0] r, input int start);
        for (int k = 0; k < 16; k++) if (r[(start + k) % 16]) return (start + k) % 16;
        return -1;
    endfunction

    function automatic logic [15:0] exp_ack();
        return (m_valid && o_ready) ? (16'(1) << m_src) : 16'h0;
    endfunction

    task automatic model_reset();
        m_valid = 0;
        m_src   = 0;
        m_ptr   = 0;
        m_data  = '0;
    endtask

    task automatic clock_edge();
        int w;
        @(posedge clk);
        if (!m_valid) begin
            w = pick(req, m_ptr);
            if (w >= 0) begin
                m_valid = 1;
                m_src   = w;
                m_data  = src_data[w];
            end
        end else if (o_ready) begin
            m_ptr = (m_src + 1) % 16;
            w = pick(req & ~(16'(1) << m_src), m_ptr);
            if (w >= 0) begin
                m_src  = w;
                m_data = src_data[w];
            end else m_valid = 0;
        end
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 0;
        req = '0;
        o_ready = 0;
        model_reset();
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 16; i++) src_data[i] = 32'hDEAD0000 + i;
        rst_n = 0;
        req = 16'h0010;
        o_ready = 1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({o_valid, busy, o_src, o_data, ack} !== 54'h0) begin
            bad++;
            $display("FAIL reset_state: got v=%b b=%b src=%0d data=%h ack=%h want all zero", o_valid, busy, o_src, o_data, ack);
        end
        @(negedge clk);
        rst_n = 1;
        #1;
        total++;
        if (ack !== 16'h0) begin bad++; $display("FAIL reset_idle_ack: got %h want 0000", ack); end
        clock_edge();
        total++;
        if (o_valid !== 1'b1 || o_src !== 4'd4 || o_data !== 32'hDEAD0004) begin
            bad++;
            $display("FAIL first_grant: got v=%b src=%0d data=%h want v=1 src=4 data=dead0004", o_valid, o_src, o_data);
        end
        #1;
        total++;
        if (ack !== 16'h0010) begin bad++; $display("FAIL first_ack: got %h want 0010", ack); end
        clock_edge();
        req = 16'h0048;
        clock_edge();
        total++;
        if (o_valid !== 1'b1 || o_src !== 4'd6) begin
            bad++;
            $display("FAIL ptr_after_ack: got v=%b src=%0d want v=1 src=6", o_valid, o_src);
        end
    endtask

    task automatic test_rotation();
        do_reset();
        for (int i = 0; i < 16; i++) src_data[i] = 32'h1000 + i;
        req = 16'hFFFF;
        o_ready = 1;
        clock_edge();
        for (int k = 0; k < 17; k++) begin
            total++;
            if (o_src !== 4'(k % 16) || o_data !== 32'h1000 + 32'(k % 16) || busy !== 1'b1) begin
                bad++;
                $display("FAIL rotation[%0d]: got src=%0d data=%h busy=%b want src=%0d data=%h busy=1",
                         k, o_src, o_data, busy, k % 16, 32'h1000 + (k % 16));
            end
            clock_edge();
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] held;
        do_reset();
        held = $urandom;
        src_data[0] = held;
        req = 16'h0101;
        o_ready = 0;
        clock_edge();
        for (int k = 0; k < 5; k++) begin
            src_data[0] = $urandom;
            #1;
            total++;
            if (ack !== 16'h0 || o_src !== 4'd0 || o_data !== held) begin
                bad++;
                $display("FAIL backpressure[%0d]: got ack=%h src=%0d data=%h want ack=0000 src=0 data=%h", k, ack, o_src, o_data, held);
            end
            clock_edge();
        end
        o_ready = 1;
        #1;
        total++;
        if (ack !== 16'h0001) begin bad++; $display("FAIL bp_release_ack: got %h want 0001", ack); end
        clock_edge();
        total++;
        if (o_src !== 4'd8 || o_data !== src_data[8]) begin
            bad++;
            $display("FAIL bp_next: got src=%0d data=%h want src=8 data=%h", o_src, o_data, src_data[8]);
        end
        clock_edge();
        total++;
        if (o_valid !== 1'b1 || o_src !== 4'd0 || o_data !== src_data[0]) begin
            bad++;
            $display("FAIL bp_return: got v=%b src=%0d data=%h want v=1 src=0 data=%h", o_valid, o_src, o_data, src_data[0]);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        req = 16'h4000;
        o_ready = 1;
        clock_edge();
        clock_edge();
        req = 16'h8001;
        clock_edge();
        total++;
        if (o_valid !== 1'b1 || o_src !== 4'd15) begin
            bad++;
            $display("FAIL wrap_first: got v=%b src=%0d want v=1 src=15", o_valid, o_src);
        end
        clock_edge();
        total++;
        if (o_valid !== 1'b1 || o_src !== 4'd0) begin
            bad++;
            $display("FAIL wrap_second: got v=%b src=%0d want v=1 src=0", o_valid, o_src);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        req = 16'h8002;
        o_ready = 1;
        clock_edge();
        clock_edge();
        o_ready = 0;
        clock_edge();
        o_ready = 1;
        #2;
        rst_n = 0;
        model_reset();
        #1;
        total++;
        if (o_valid !== 1'b0 || busy !== 1'b0 || ack !== 16'h0) begin
            bad++;
            $display("FAIL async_reset: got v=%b busy=%b ack=%h want v=0 busy=0 ack=0000", o_valid, busy, ack);
        end
        @(negedge clk);
        rst_n = 1;
        clock_edge();
        total++;
        if (o_valid !== 1'b1 || o_src !== 4'd1) begin
            bad++;
            $display("FAIL async_reset_ptr: got v=%b src=%0d want v=1 src=1", o_valid, o_src);
        end
    endtask

    task automatic test_idle();
        do_reset();
        for (int k = 0; k < 6; k++) begin
            o_ready = k[0];
            #1;
            total++;
            if (ack !== 16'h0) begin bad++; $display("FAIL idle_ack[%0d]: got %h want 0000", k, ack); end
            clock_edge();
            total++;
            if (o_valid !== 1'b0 || busy !== 1'b0) begin
                bad++;
                $display("FAIL idle_state[%0d]: got v=%b busy=%b want 0 0", k, o_valid, busy);
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 400; k++) begin
            req = 16'($urandom & $urandom);
            o_ready = ($urandom % 4) != 0;
            for (int i = 0; i < 16; i++) src_data[i] = $urandom;
            #1;
            total++;
            if (ack !== exp_ack()) begin bad++; $display("FAIL rand_ack[%0d]: got %h want %h", k, ack, exp_ack()); end
            clock_edge();
            total++;
            if (o_valid !== m_valid || busy !== m_valid) begin
                bad++;
                $display("FAIL rand_valid[%0d]: got v=%b busy=%b want %b", k, o_valid, busy, m_valid);
            end
            if (m_valid) begin
                total++;
                if (o_src !== 4'(m_src) || o_data !== m_data) begin
                    bad++;
                    $display("FAIL rand_payload[%0d]: got src=%0d data=%h want src=%0d data=%h", k, o_src, o_data, m_src, m_data);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_rotation();
        test_backpressure();
        test_wrap();
        test_async_reset();
        test_idle();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
